// File: rtl/idma_lite_mc_arbiter_pkg.sv
// Shared types for the multi-channel iDMA-lite front stage.
package idma_lite_mc_arbiter_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic       error;
        logic [1:0] cause;
        logic       last;
    } idma_lite_mc_rsp_t;

endpackage

// File: rtl/idma_lite_mc_arbiter_fifo.sv
// Route FIFO holding the channel index of every request accepted by the backend.
module idma_lite_mc_arbiter_fifo #(
    parameter int Depth = 8,
    parameter int Width = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic [CntW-1:0]  usage_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push, pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (int'(p) == Depth - 1) ? '0 : p + 1'b1;
    endfunction

    assign push    = push_i & (int'(cnt_q) < Depth);
    assign pop     = pop_i & (cnt_q != '0);
    assign data_o  = mem[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_lite_mc_arbiter.sv
// Round-robin arbiter from N request channels onto one iDMA-lite backend,
// with in-order response routing back to the issuing channel.
module idma_lite_mc_arbiter
    import idma_lite_mc_arbiter_pkg::*;
#(
    parameter int NumChannels    = 4,
    parameter int AddrWidth      = 32,
    parameter int TFLenWidth     = 32,
    parameter int MaxOutstanding = 8,
    parameter int ChanIdxWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumChannels-1:0]            ch_req_valid_i,
    output logic [NumChannels-1:0]            ch_req_ready_o,
    input  logic [NumChannels*TFLenWidth-1:0] ch_req_length_i,
    input  logic [NumChannels*AddrWidth-1:0]  ch_req_src_addr_i,
    input  logic [NumChannels*AddrWidth-1:0]  ch_req_dst_addr_i,
    input  logic [NumChannels-1:0]            ch_req_last_i,
    output logic [NumChannels-1:0]            ch_rsp_valid_o,
    input  logic [NumChannels-1:0]            ch_rsp_ready_i,
    output logic                              ch_rsp_error_o,
    output logic [1:0]                        ch_rsp_cause_o,
    output logic                              ch_rsp_last_o,
    output logic [NumChannels*CntWidth-1:0]   ch_outstanding_o,
    output logic [NumChannels-1:0]            ch_busy_o,
    output logic                              be_req_valid_o,
    input  logic                              be_req_ready_i,
    output logic [TFLenWidth-1:0]             be_req_length_o,
    output logic [AddrWidth-1:0]              be_req_src_addr_o,
    output logic [AddrWidth-1:0]              be_req_dst_addr_o,
    output logic                              be_req_last_o,
    input  logic                              be_rsp_valid_i,
    output logic                              be_rsp_ready_o,
    input  logic                              be_rsp_error_i,
    input  logic [1:0]                        be_rsp_cause_i,
    input  logic                              be_rsp_last_i
);

    typedef logic [ChanIdxWidth-1:0] chan_idx_t;

    chan_idx_t          rr_ptr_q, lock_idx_q, rr_pick, grant, head;
    logic               lock_q, accept, req_hs, rsp_hs, fifo_empty;
    logic [CntWidth-1:0] fifo_usage;
    logic [CntWidth-1:0] cnt_q [NumChannels];
    logic [NumChannels-1:0] inc, dec;
    idma_lite_mc_rsp_t  be_rsp;

    function automatic chan_idx_t next_chan(input chan_idx_t i);
        return (int'(i) == NumChannels - 1) ? '0 : i + 1'b1;
    endfunction

    // First valid channel at or after the RR pointer.
    always_comb begin
        int k;
        logic found;
        rr_pick = rr_ptr_q;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NumChannels; i++) begin
            k = (int'(rr_ptr_q) + i) % NumChannels;
            if (!found && ch_req_valid_i[k]) begin
                found   = 1'b1;
                rr_pick = chan_idx_t'(k);
            end
        end
    end

    // A stalled grant is locked so later arrivals cannot preempt it.
    assign grant          = lock_q ? lock_idx_q : rr_pick;
    assign accept         = int'(fifo_usage) < MaxOutstanding;
    assign be_req_valid_o = accept & (lock_q ? ch_req_valid_i[grant] : |ch_req_valid_i);
    assign req_hs         = be_req_valid_o & be_req_ready_i;

    assign be_req_length_o   = ch_req_length_i[int'(grant)*TFLenWidth +: TFLenWidth];
    assign be_req_src_addr_o = ch_req_src_addr_i[int'(grant)*AddrWidth +: AddrWidth];
    assign be_req_dst_addr_o = ch_req_dst_addr_i[int'(grant)*AddrWidth +: AddrWidth];
    assign be_req_last_o     = ch_req_last_i[grant];

    assign be_rsp         = '{error: be_rsp_error_i, cause: be_rsp_cause_i, last: be_rsp_last_i};
    assign ch_rsp_error_o = be_rsp.error;
    assign ch_rsp_cause_o = be_rsp.cause;
    assign ch_rsp_last_o  = be_rsp.last;

    always_comb begin
        ch_req_ready_o = '0;
        ch_rsp_valid_o = '0;
        be_rsp_ready_o = 1'b0;
        inc            = '0;
        dec            = '0;
        if (req_hs) begin
            ch_req_ready_o[grant] = 1'b1;
            inc[grant]            = 1'b1;
        end
        if (!fifo_empty) begin
            ch_rsp_valid_o[head] = be_rsp_valid_i;
            be_rsp_ready_o       = ch_rsp_ready_i[head];
        end
        if (rsp_hs) dec[head] = 1'b1;
    end

    assign rsp_hs = be_rsp_valid_i & be_rsp_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int c = 0; c < NumChannels; c++) cnt_q[c] <= '0;
        end else begin
            if (req_hs) rr_ptr_q <= next_chan(grant);
            lock_q     <= be_req_valid_o & ~be_req_ready_i;
            lock_idx_q <= grant;
            for (int c = 0; c < NumChannels; c++) begin
                if (inc[c] && !dec[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
                else if (dec[c] && !inc[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_cnt_out
        assign ch_outstanding_o[c*CntWidth +: CntWidth] = cnt_q[c];
        assign ch_busy_o[c]                             = |cnt_q[c];
    end

    idma_lite_mc_arbiter_fifo #(
        .Depth (MaxOutstanding),
        .Width (ChanIdxWidth),
        .CntW  (CntWidth)
    ) i_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_hs),
        .data_i  (grant),
        .pop_i   (rsp_hs),
        .data_o  (head),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage)
    );

    // A response with nothing outstanding has no channel to go to.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(be_rsp_valid_i && fifo_empty));

endmodule
